planta_termica: RTL
===================

# planta_termica

Closed-loop thermal plant emulator: the source side of the temperature interface. It consumes the `calefactor`/`ventilador` actuator outputs of `monitoreo_top` and produces the `temp_entrada` sample stream that feeds it. Heating, cooling, drift toward ambient and injected disturbances are modelled on a prescaled thermal tick. This lets benches close the control loop without a scripted temperature sequence. Units: tenths of °C (220 = 22.0 °C).

## Interface
- `TEMP_W`, 10: temperature width, unsigned.
- `T_INICIAL`, 220: temperature after reset.
- `T_AMBIENTE`, 220: drift target when no actuator is on.
- `PASO_CALEF`, 2: increment per tick while heating.
- `PASO_VENT`, 2: decrement per tick while cooling.
- `PASO_DERIVA`, 1: maximum step toward ambient per tick.
- `DIV_TICK`, 4: clock cycles per thermal tick (≥1).
- `T_MIN`, 0 / `T_MAX`, 1000: saturation limits.
- `clk`  in  1  single clock, rising edge.
- `arst`  in  1  asynchronous, active-high reset.
- `calefactor`  in  1  heater request.
- `ventilador`  in  1  fan request.
- `carga_en`  in  1  one-cycle load strobe.
- `carga_valor`  in  TEMP_W  load value.
- `perturb_en`  in  1  one-cycle disturbance strobe.
- `perturb_delta`  in  8  signed disturbance, two's complement.
- `temp_salida`  out  TEMP_W  current temperature, connects to `temp_entrada`.
- `temp_valida`  out  1  one-cycle pulse on every temperature update.
- `modo`  out  2  plant state.

## Operation
- **State register `modo`** is updated every clock from the actuator inputs:
  - REPOSO=00: neither input asserted.
  - CALENTANDO=01: `calefactor` only.
  - ENFRIANDO=10: `ventilador` only.
  - CONFLICTO=11: both asserted.
  - Any state can go to any state in one cycle.
- **Prescaler** counts 0..DIV_TICK-1. Tick occurs when count==DIV_TICK-1, then the count wraps to 0. With DIV_TICK=1, every cycle is a tick.
- **Update priority per cycle** (highest first):
  1. `carga_en`: `temp_salida` ← `carga_valor`, clamped to [T_MIN, T_MAX]. Prescaler ← 0.
  2. `perturb_en`: `temp_salida` ← `temp_salida` + sign-extended `perturb_delta`, saturated. Prescaler keeps counting.
  3. Tick: apply the rule for the registered `modo`:
     - CALENTANDO: +PASO_CALEF.
     - ENFRIANDO: −PASO_VENT.
     - REPOSO: move toward T_AMBIENTE by min(PASO_DERIVA, |T_AMBIENTE−temp|), with no overshoot.
     - CONFLICTO: hold.
- **Arithmetic:** all sums are computed signed at TEMP_W+2 bits, then saturated to [T_MIN, T_MAX]. There is no wrap-around.
- **Lost events:** a perturbation that coincides with a load is discarded. A tick that coincides with a load or a perturbation is skipped; the lower-priority event is lost, not deferred.
- **`temp_valida`** pulses for the cycle after any load, perturbation or tick. It pulses even when the value is unchanged (saturated, held, or at ambient).

## Timing
- **Reset values:** `temp_salida`=T_INICIAL, `modo`=REPOSO, `temp_valida`=0, prescaler=0. Reset is immediate on `arst` rising, independent of `clk`.
- **Reset mid-operation** aborts any pending tick or load. The first tick after release occurs on the DIV_TICK-th rising edge.
- **Actuator-to-mode latency:** 1 cycle. The temperature responds at the first tick after `modo` has changed.
- **Load/perturb latency:** `temp_salida` and `temp_valida` are valid 1 cycle after the strobe edge.
- **Outputs:** all outputs are registered, with no combinational input-to-output path.

## Structure
- `monitoreo_pkg` gains:
  - `modo_planta_e`: 2-bit enum REPOSO/CALENTANDO/ENFRIANDO/CONFLICTO.
  - `temp_t`: `logic [TEMP_W-1:0]`.
  - Default constants for T_AMBIENTE, T_MIN and T_MAX, shared with the monitor thresholds (180/259).
- Sub-module `divisor_tick`:
  - Parameter DIV_TICK.
  - Ports: clk, arst, clr, tick.
  - Implements the prescaler; `clr` is driven by `carga_en`.
- Saturation is a local function inside `planta_termica`.

## Test plan
- Reset: hold `arst`=1 for 2 cycles → `temp_salida`=220, `modo`=00, `temp_valida`=0. Assert `arst` mid-ramp → outputs return to these values immediately.
- Heating: `calefactor`=1 from 220 → `modo`=01 after 1 cycle. Temperature then goes +2 every 4 cycles, reaching 230 after 5 `temp_valida` pulses.
- Cooling: load 300, then `ventilador`=1 → sequence 298, 296, 294, with one value every 4 cycles.
- Drift: load 225 with no actuator → 224, 223, 222, 221, 220, then 220 held while `temp_valida` keeps pulsing every 4 cycles.
- Saturation: load 999 with `calefactor`=1 → 1000, then held at 1000. Load 1 with `ventilador`=1 → 0, then held at 0.
- Conflict and disturbance: both actuators on → `modo`=11 and temperature held. `perturb_delta`=−50 at 220 → 170 one cycle later. A simultaneous load of 260 and perturbation → 260, perturbation discarded.

Source files
------------

// File: rtl/monitoreo_pkg.sv
// Shared types and default thermal constants for the monitor and the plant emulator.
package monitoreo_pkg;

   localparam int unsigned TEMP_W_DEF = 10;

   typedef logic [TEMP_W_DEF-1:0] temp_t;

   typedef enum logic [1:0] {
      REPOSO     = 2'b00,
      CALENTANDO = 2'b01,
      ENFRIANDO  = 2'b10,
      CONFLICTO  = 2'b11
   } modo_planta_e;

   // Tenths of a degree Celsius
   localparam int T_AMBIENTE_DEF = 220;
   localparam int T_MIN_DEF      = 0;
   localparam int T_MAX_DEF      = 1000;
   localparam int UMBRAL_BAJO    = 180;
   localparam int UMBRAL_ALTO    = 259;

endpackage

// File: rtl/divisor_tick.sv
// Thermal-tick prescaler: counts 0..DIV_TICK-1, flags the last count, clr restarts at 0.
module divisor_tick #(
   parameter int unsigned DIV_TICK = 4
) (
   input  logic clk,
   input  logic arst,
   input  logic clr,
   output logic tick
);

   localparam int unsigned CNT_W = (DIV_TICK > 1) ? $clog2(DIV_TICK) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIV_TICK - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Next count: wrap on the tick count, restart on clear
   always_comb begin
      tick  = (cnt_q == CNT_MAX);
      cnt_d = cnt_q + 1'b1;
      if (clr || tick) begin
         cnt_d = '0;
      end
   end

   // Counter register
   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/planta_termica.sv
// Closed-loop thermal plant emulator: heating, cooling, drift to ambient and
// injected disturbances applied on a prescaled tick, saturated to [T_MIN, T_MAX].
module planta_termica
   import monitoreo_pkg::*;
#(
   parameter int unsigned TEMP_W      = TEMP_W_DEF,
   parameter int          T_INICIAL   = 220,
   parameter int          T_AMBIENTE  = T_AMBIENTE_DEF,
   parameter int          PASO_CALEF  = 2,
   parameter int          PASO_VENT   = 2,
   parameter int          PASO_DERIVA = 1,
   parameter int unsigned DIV_TICK    = 4,
   parameter int          T_MIN       = T_MIN_DEF,
   parameter int          T_MAX       = T_MAX_DEF
) (
   input  logic              clk,
   input  logic              arst,
   input  logic              calefactor,
   input  logic              ventilador,
   input  logic              carga_en,
   input  logic [TEMP_W-1:0] carga_valor,
   input  logic              perturb_en,
   input  logic [7:0]        perturb_delta,
   output logic [TEMP_W-1:0] temp_salida,
   output logic              temp_valida,
   output logic [1:0]        modo
);

   localparam int unsigned AW = TEMP_W + 2;

   localparam logic signed [AW-1:0] MIN_A    = AW'(T_MIN);
   localparam logic signed [AW-1:0] MAX_A    = AW'(T_MAX);
   localparam logic signed [AW-1:0] AMB_A    = AW'(T_AMBIENTE);
   localparam logic signed [AW-1:0] CALEF_A  = AW'(PASO_CALEF);
   localparam logic signed [AW-1:0] VENT_A   = AW'(PASO_VENT);
   localparam logic signed [AW-1:0] DERIVA_A = AW'(PASO_DERIVA);

   function automatic logic [TEMP_W-1:0] saturar(input logic signed [AW-1:0] v);
      logic signed [AW-1:0] r;
      r = v;
      if (v < MIN_A) r = MIN_A;
      else if (v > MAX_A) r = MAX_A;
      return r[TEMP_W-1:0];
   endfunction

   logic [TEMP_W-1:0]    temp_q, temp_d;
   logic                 valida_q, valida_d;
   modo_planta_e         modo_q, modo_d;
   logic                 tick;
   logic signed [AW-1:0] temp_a, carga_a, delta_a, dif_amb, deriva_a;

   divisor_tick #(
      .DIV_TICK (DIV_TICK)
   ) u_divisor_tick (
      .clk  (clk),
      .arst (arst),
      .clr  (carga_en),
      .tick (tick)
   );

   // Plant mode follows the actuator requests one cycle later
   always_comb begin
      modo_d = REPOSO;
      unique case ({ventilador, calefactor})
         2'b00:   modo_d = REPOSO;
         2'b01:   modo_d = CALENTANDO;
         2'b10:   modo_d = ENFRIANDO;
         default: modo_d = CONFLICTO;
      endcase
   end

   // Next temperature by priority: load, then disturbance, then tick rule
   always_comb begin
      temp_a  = signed'({2'b00, temp_q});
      carga_a = signed'({2'b00, carga_valor});
      delta_a = signed'({{(AW-8){perturb_delta[7]}}, perturb_delta});
      dif_amb = AMB_A - temp_a;
      // Within one step of ambient the target itself is taken, so no overshoot
      if (dif_amb > DERIVA_A)       deriva_a = temp_a + DERIVA_A;
      else if (dif_amb < -DERIVA_A) deriva_a = temp_a - DERIVA_A;
      else                          deriva_a = AMB_A;

      temp_d   = temp_q;
      valida_d = 1'b0;
      if (carga_en) begin
         temp_d   = saturar(carga_a);
         valida_d = 1'b1;
      end else if (perturb_en) begin
         temp_d   = saturar(temp_a + delta_a);
         valida_d = 1'b1;
      end else if (tick) begin
         valida_d = 1'b1;
         unique case (modo_q)
            CALENTANDO: temp_d = saturar(temp_a + CALEF_A);
            ENFRIANDO:  temp_d = saturar(temp_a - VENT_A);
            REPOSO:     temp_d = saturar(deriva_a);
            default:    temp_d = temp_q;
         endcase
      end
   end

   // State and output registers
   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         temp_q   <= TEMP_W'(T_INICIAL);
         valida_q <= 1'b0;
         modo_q   <= REPOSO;
      end else begin
         temp_q   <= temp_d;
         valida_q <= valida_d;
         modo_q   <= modo_d;
      end
   end

   assign temp_salida = temp_q;
   assign temp_valida = valida_q;
   assign modo        = modo_q;

endmodule
